// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// One hex decoder is shared across all digits. Each slot starts with a few blanking
// cycles (all anodes off) to suppress ghosting. The displayed value is double-buffered
// (pending -> shadow) and only swaps at a frame boundary or while idle, so frames never tear.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            load,
    input  logic [4*NUM_DIGITS-1:0]         value_in,
    input  logic [NUM_DIGITS-1:0]           blank_in,
    output logic [3:0]                      hex_sel,
    output logic [NUM_DIGITS-1:0]           an_n,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_done
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned CntW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_v_q, pend_v_d;
    logic [3:0]              hex_sel_q, hex_sel_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_done_q, frame_done_d;

    logic wrap;
    logic commit;
    logic last_blank;
    logic last_slot;
    logic last_digit;

    assign last_blank = (cnt_q == CntW'(BLANK_CYCLES - 1));
    assign last_slot  = (cnt_q == CntW'(REFRESH_DIV - 1));
    assign last_digit = (digit_q == IdxW'(NUM_DIGITS - 1));

    // Scan sequencing: cnt runs across the whole slot, blanking covers its first cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        wrap    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                digit_d = '0;
                if (enable) begin
                    state_d = StBlank;
                end
            end
            StBlank: begin
                if (!enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    digit_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (last_blank) begin
                        state_d = StOn;
                    end
                end
            end
            StOn: begin
                if (!enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    digit_d = '0;
                end else if (last_slot) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    if (last_digit) begin
                        digit_d = '0;
                        wrap    = 1'b1;
                    end else begin
                        digit_d = digit_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                digit_d = '0;
            end
        endcase
    end

    // Double buffer: a load on a commit cycle bypasses the pending stage entirely.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        pend_val_d     = pend_val_q;
        pend_blank_d   = pend_blank_q;
        pend_v_d       = pend_v_q;
        commit         = (state_q == StIdle) || wrap;
        if (commit) begin
            if (load) begin
                shadow_val_d   = value_in;
                shadow_blank_d = blank_in;
                pend_v_d       = 1'b0;
            end else if (pend_v_q) begin
                shadow_val_d   = pend_val_q;
                shadow_blank_d = pend_blank_q;
                pend_v_d       = 1'b0;
            end
        end else if (load) begin
            pend_val_d   = value_in;
            pend_blank_d = blank_in;
            pend_v_d     = 1'b1;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_comb begin
        an_n_d       = '1;
        hex_sel_d    = hex_sel_q;
        frame_done_d = wrap;
        if (state_d == StOn && !shadow_blank_d[digit_d]) begin
            an_n_d[digit_d] = 1'b0;
        end
        if (state_d == StBlank && state_q != StBlank) begin
            hex_sel_d = shadow_val_d[{digit_d, 2'b00} +: 4];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            digit_q        <= '0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            pend_val_q     <= '0;
            pend_blank_q   <= '0;
            pend_v_q       <= 1'b0;
            hex_sel_q      <= '0;
            an_n_q         <= '1;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            pend_val_q     <= pend_val_d;
            pend_blank_q   <= pend_blank_d;
            pend_v_q       <= pend_v_d;
            hex_sel_q      <= hex_sel_d;
            an_n_q         <= an_n_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign hex_sel    = hex_sel_q;
    assign an_n       = an_n_q;
    assign digit_idx  = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a behavioural model predicts every cycle's outputs
// from a linear scan position, a monitor compares them on the falling edge.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  hex_sel;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .value_in  (value_in),
        .blank_in  (blank_in),
        .hex_sel   (hex_sel),
        .an_n      (an_n),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    // Model state: scan position counts cycles since the scan (re)started.
    bit          m_run = 0;
    int          m_p = 0;
    logic [15:0] sh_v = '0;
    logic [15:0] pd_v = '0;
    logic [3:0]  sh_b = '0;
    logic [3:0]  pd_b = '0;
    bit          pv = 0;
    logic [3:0]  m_hex = '0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: predicts outputs that follow each rising edge.
    always @(posedge clk) begin : model
        exp_t e;
        bit   wrap;
        bit   commit;
        int   d;
        int   ph;
        if (rst) begin
            m_run = 0; m_p = 0; sh_v = '0; sh_b = '0; pd_v = '0; pd_b = '0; pv = 0;
            m_hex = '0;
            e = '{hex: 4'h0, an: 4'hF, idx: 2'd0, fd: 1'b0};
        end else begin
            wrap   = m_run && enable && (m_p % FR == FR - 1);
            commit = !m_run || wrap;
            if (commit && load) begin
                sh_v = value_in; sh_b = blank_in; pv = 0;
            end else if (commit && pv) begin
                sh_v = pd_v; sh_b = pd_b; pv = 0;
            end else if (!commit && load) begin
                pd_v = value_in; pd_b = blank_in; pv = 1;
            end
            if (!enable) begin
                m_run = 0;
            end else if (!m_run) begin
                m_run = 1; m_p = 0;
            end else begin
                m_p = m_p + 1;
            end
            if (m_run) begin
                d     = (m_p / RD) % ND;
                ph    = m_p % RD;
                m_hex = sh_v[4*d +: 4];
                e.an  = (ph < BC || sh_b[d]) ? 4'hF : ~(4'b0001 << d);
                e.hex = m_hex;
                e.idx = 2'(d);
                e.fd  = wrap;
            end else begin
                e = '{hex: m_hex, an: 4'hF, idx: 2'd0, fd: 1'b0};
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per cycle and compares away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hex_sel", int'(hex_sel), int'(e.hex));
            chk("an_n", int'(an_n), int'(e.an));
            chk("digit_idx", int'(digit_idx), int'(e.idx));
            chk("frame_done", int'(frame_done), int'(e.fd));
            chk("one_hot_anode", int'($countones(~an_n) <= 1), 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] b);
        value_in = v;
        blank_in = b;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
    endtask

    // Advance until the model is at scan position pos (mod frame); bounded.
    task automatic wait_pos(input int pos, input string nm);
        int k = 0;
        while (!(m_run && (m_p % FR == pos)) && k < 200) begin
            tick(1);
            k++;
        end
        checks++;
        if (k >= 200) begin
            failures++;
            $display("FAIL wait_%s: position %0d not reached, got timeout expected reach", nm, pos);
        end
    endtask

    initial begin
        tick(2);
        chk("reset_an", int'(an_n), 'hF);
        chk("reset_hex", int'(hex_sel), 0);
        chk("reset_fd", int'(frame_done), 0);
        rst = 1'b0;

        // Basic scan of 1A3F
        pulse_load(16'h1A3F, 4'b0000);
        enable = 1'b1;
        tick(1);
        chk("s1_blank_an", int'(an_n), 'hF);
        tick(2);
        chk("s1_d0_an", int'(an_n), 'hE);
        chk("s1_d0_hex", int'(hex_sel), 'hF);
        wait_pos(10, "s1_d1");
        chk("s1_d1_hex", int'(hex_sel), 'h3);
        chk("s1_d1_an", int'(an_n), 'hD);
        wait_pos(18, "s1_d2");
        chk("s1_d2_hex", int'(hex_sel), 'hA);
        chk("s1_d2_an", int'(an_n), 'hB);
        wait_pos(26, "s1_d3");
        chk("s1_d3_hex", int'(hex_sel), 'h1);
        chk("s1_d3_an", int'(an_n), 'h7);

        // Mid-frame load must not tear the current frame
        wait_pos(10, "s2_load");
        pulse_load(16'h0000, 4'b0000);
        wait_pos(18, "s2_d2");
        chk("s2_d2_hex", int'(hex_sel), 'hA);
        wait_pos(26, "s2_d3");
        chk("s2_d3_hex", int'(hex_sel), 'h1);
        wait_pos(2, "s2_next");
        chk("s2_next_hex", int'(hex_sel), 'h0);

        // Blank mask on digit 2
        wait_pos(5, "s3_load");
        pulse_load(16'h1234, 4'b0100);
        wait_pos(0, "s3_frame");
        wait_pos(20, "s3_d2");
        chk("s3_d2_an", int'(an_n), 'hF);
        chk("s3_d2_idx", int'(digit_idx), 2);

        // Disable during digit 2 ON, then re-enable
        enable = 1'b0;
        tick(1);
        chk("s4_off_an", int'(an_n), 'hF);
        chk("s4_off_idx", int'(digit_idx), 0);
        chk("s4_off_fd", int'(frame_done), 0);
        tick(3);
        enable = 1'b1;
        tick(2);
        chk("s4_re_blank", int'(an_n), 'hF);
        tick(1);
        chk("s4_re_on", int'(an_n), 'hE);
        chk("s4_re_hex", int'(hex_sel), 'h4);

        // Load on the wrap cycle goes straight to the shadow
        wait_pos(FR - 1, "s5_wrap");
        pulse_load(16'h5555, 4'b0000);
        chk("s5_fd", int'(frame_done), 1);
        for (int s = 0; s < ND; s++) begin
            wait_pos(s * RD + BC, "s5_slot");
            chk("s5_hex", int'(hex_sel), 'h5);
        end
        wait_pos(BC, "s5_again");
        chk("s5_again_hex", int'(hex_sel), 'h5);

        // Reset mid-ON with pending data held
        wait_pos(4, "s6_load");
        pulse_load(16'h9876, 4'b0000);
        wait_pos(11, "s6_rst");
        rst = 1'b1;
        tick(1);
        chk("s6_rst_an", int'(an_n), 'hF);
        chk("s6_rst_hex", int'(hex_sel), 0);
        chk("s6_rst_idx", int'(digit_idx), 0);
        rst = 1'b0;
        tick(3);
        chk("s6_re_hex", int'(hex_sel), 0);
        chk("s6_re_an", int'(an_n), 'hE);
        wait_pos(BC, "s6_next");
        chk("s6_next_hex", int'(hex_sel), 0);

        // Randomised traffic, all checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            value_in = 16'($urandom);
            blank_in = 4'($urandom);
            load     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            rst      = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        load   = 1'b0;
        rst    = 1'b0;
        enable = 1'b0;
        tick(3);
        chk("queue_drained", exp_q.size() <= 1 ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
